// File: rtl/laser_tx_array.sv
// laser_tx_array: multi-channel framed laser transmitter.
//   Accepts one DATA_WIDTH word per channel through a valid/ready handshake.
//   It then serialises all channels in lock-step: a start bit (0), the data
//   LSB first, an optional even-parity bit, and STOP_BITS stop bits (1).
//   Each bit is held for BIT_DIV clocks. The idle line level is 1.
// Optional build macro: LASER_TX_PARITY_EN inserts a per-channel even-parity
//   bit after the data bits. The frame grows by one bit period.
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   en           transmitter enable; also biases the lasers
//   data_in      channel c word at [c*DATA_WIDTH +: DATA_WIDTH]
//   data_valid   source has a word for every channel
//   data_ready   block accepts data_in this cycle (IDLE and en)
//   laser_data   registered modulated bit per channel
//   laser_power  per-channel laser bias, follows en
//   busy         frame in progress
//   done         one-cycle pulse during the last clock of a frame
module laser_tx_array #(
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 8,
  parameter int BIT_DIV    = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           en,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic                           data_valid,
  output logic                           data_ready,
  output logic [CHANNELS-1:0]            laser_data,
  output logic [CHANNELS-1:0]            laser_power,
  output logic                           busy,
  output logic                           done
);

`ifdef LASER_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int LAST_IDX = DATA_WIDTH + STOP_BITS + PAR_BITS;
  localparam int DIV_W    = $clog2(BIT_DIV) + 1;
  localparam int IDX_W    = $clog2(LAST_IDX + 1) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(BIT_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE      = DIV_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(LAST_IDX);
  localparam logic [IDX_W-1:0] IDX_DATA_END = IDX_W'(DATA_WIDTH);
  localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);
`ifdef LASER_TX_PARITY_EN
  localparam logic [IDX_W-1:0] IDX_PAR      = IDX_W'(DATA_WIDTH + 1);
`endif

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                         state_r;
  logic [DIV_W-1:0]               div_r;
  logic [IDX_W-1:0]               bit_idx_r;
  logic [CHANNELS*DATA_WIDTH-1:0] shift_r;
`ifdef LASER_TX_PARITY_EN
  logic [CHANNELS-1:0]            parity_r;

  // Even parity of each channel's word.
  function automatic logic [CHANNELS-1:0] even_parity(
    input logic [CHANNELS*DATA_WIDTH-1:0] w
  );
    logic [CHANNELS-1:0] p;
    p = {CHANNELS{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      p[c] = ^w[c*DATA_WIDTH +: DATA_WIDTH];
    end
    return p;
  endfunction
`endif

  logic                           div_wrap_s;
  logic                           last_s;
  logic                           done_nxt_s;
  logic [DIV_W-1:0]               div_nxt_s;
  logic [IDX_W-1:0]               idx_nxt_s;
  logic [CHANNELS-1:0]            lsb_s;
  logic [CHANNELS-1:0]            bit_nxt_s;
  logic [CHANNELS*DATA_WIDTH-1:0] shift_nxt_s;

  assign laser_power = {CHANNELS{en}};
  assign data_ready  = (state_r == IDLE) & en;

  // Next divider/bit index, next line value and look-ahead for the done pulse.
  always_comb begin
    div_wrap_s  = (div_r == DIV_LAST);
    last_s      = div_wrap_s && (bit_idx_r == IDX_LAST);
    div_nxt_s   = {DIV_W{1'b0}};
    idx_nxt_s   = bit_idx_r;
    lsb_s       = {CHANNELS{1'b0}};
    shift_nxt_s = shift_r;
    if (div_wrap_s) begin
      div_nxt_s = {DIV_W{1'b0}};
      idx_nxt_s = bit_idx_r + IDX_ONE;
    end else begin
      div_nxt_s = div_r + DIV_ONE;
      idx_nxt_s = bit_idx_r;
    end
    // done is registered, so it is raised one edge ahead of the final cycle
    done_nxt_s = (idx_nxt_s == IDX_LAST) && (div_nxt_s == DIV_LAST);
    for (int c = 0; c < CHANNELS; c++) begin
      lsb_s[c] = shift_r[c*DATA_WIDTH];
      shift_nxt_s[c*DATA_WIDTH +: DATA_WIDTH] = shift_r[c*DATA_WIDTH +: DATA_WIDTH] >> 1;
    end
    // Index 0 (start bit) is loaded at transfer, so idx_nxt_s is at least 1 here.
    if (idx_nxt_s <= IDX_DATA_END) begin
      bit_nxt_s = lsb_s;
`ifdef LASER_TX_PARITY_EN
    end else if (idx_nxt_s == IDX_PAR) begin
      bit_nxt_s = parity_r;
`endif
    end else begin
      bit_nxt_s = {CHANNELS{1'b1}};
    end
  end

  // Transmit FSM with registered line, busy and done outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      div_r      <= {DIV_W{1'b0}};
      bit_idx_r  <= {IDX_W{1'b0}};
      shift_r    <= {(CHANNELS*DATA_WIDTH){1'b0}};
`ifdef LASER_TX_PARITY_EN
      parity_r   <= {CHANNELS{1'b0}};
`endif
      laser_data <= {CHANNELS{1'b1}};
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (en && data_valid) begin
            state_r    <= SEND;
            shift_r    <= data_in;
`ifdef LASER_TX_PARITY_EN
            parity_r   <= even_parity(data_in);
`endif
            div_r      <= {DIV_W{1'b0}};
            bit_idx_r  <= {IDX_W{1'b0}};
            laser_data <= {CHANNELS{1'b0}};
            busy       <= 1'b1;
            done       <= 1'b0;
          end else begin
            laser_data <= {CHANNELS{1'b1}};
            busy       <= 1'b0;
            done       <= 1'b0;
          end
        end
        SEND: begin
          if (!en || last_s) begin
            // Abort (en dropped) or normal end of frame: back to idle line.
            state_r    <= IDLE;
            div_r      <= {DIV_W{1'b0}};
            bit_idx_r  <= {IDX_W{1'b0}};
            laser_data <= {CHANNELS{1'b1}};
            busy       <= 1'b0;
            done       <= 1'b0;
          end else if (div_wrap_s) begin
            div_r      <= div_nxt_s;
            bit_idx_r  <= idx_nxt_s;
            shift_r    <= shift_nxt_s;
            laser_data <= bit_nxt_s;
            done       <= done_nxt_s;
          end else begin
            div_r      <= div_nxt_s;
            done       <= done_nxt_s;
          end
        end
        default: begin
          state_r    <= IDLE;
          div_r      <= {DIV_W{1'b0}};
          bit_idx_r  <= {IDX_W{1'b0}};
          laser_data <= {CHANNELS{1'b1}};
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule
